// File: rtl/mdu_pkg.sv
// rtl/mdu_pkg.sv - shared encodings and constants for the HI/LO multiply-divide unit
package mdu_pkg;

  localparam int MDU_DATA_WIDTH = 32;
  localparam int MDU_ITERS      = MDU_DATA_WIDTH;

  typedef enum logic [1:0] {
    OP_MULT  = 2'b00,
    OP_MULTU = 2'b01,
    OP_DIV   = 2'b10,
    OP_DIVU  = 2'b11
  } mdu_op_e;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } mdu_state_e;

  function automatic logic op_is_div(input logic [1:0] op);
    return op[1];
  endfunction

  function automatic logic op_is_signed(input logic [1:0] op);
    return ~op[0];
  endfunction

endpackage

// File: rtl/mdu_negate.sv
// rtl/mdu_negate.sv - conditional two's-complement of a word
module mdu_negate #(
  parameter int DATA_WIDTH = 32
) (
  input  logic                  i_en,
  input  logic [DATA_WIDTH-1:0] i_data,
  output logic [DATA_WIDTH-1:0] o_data
);

  assign o_data = i_en ? (~i_data + 1'b1) : i_data;

endmodule

// File: rtl/mdu_hilo.sv
// rtl/mdu_hilo.sv - iterative MIPS-style multiply/divide unit with HI/LO registers
module mdu_hilo
  import mdu_pkg::*;
#(
  parameter int DATA_WIDTH = MDU_DATA_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [1:0]            op,
  input  logic [DATA_WIDTH-1:0] a,
  input  logic [DATA_WIDTH-1:0] b,
  input  logic                  mthi,
  input  logic                  mtlo,
  input  logic [DATA_WIDTH-1:0] wdata,
  output logic                  busy,
  output logic                  done,
  output logic                  div_zero,
  output logic [DATA_WIDTH-1:0] hi,
  output logic [DATA_WIDTH-1:0] lo
);

  localparam int ITERS = DATA_WIDTH;
  localparam int CNT_W = $clog2(ITERS);

  mdu_state_e r_state, w_state_nx;

  logic [1:0]            r_op;
  logic                  r_sa, r_sb, r_dz;
  logic [DATA_WIDTH-1:0] r_acc, r_mq, r_b;
  logic [CNT_W-1:0]      r_cnt;
  logic [DATA_WIDTH-1:0] r_hi, r_lo;
  logic                  r_done, r_div_zero;

  logic                  w_last;
  logic [DATA_WIDTH-1:0] w_a_abs, w_b_abs;
  logic [DATA_WIDTH:0]   w_mul_sum, w_div_sh, w_div_diff;
  logic                  w_div_ok;
  logic [DATA_WIDTH-1:0] w_acc_nx, w_mq_nx;
  logic                  w_is_div, w_signed, w_q_neg, w_lo_zero, w_hi_neg_en;
  logic [DATA_WIDTH-1:0] w_lo_res, w_hi_neg, w_hi_res;

  assign w_last = (r_state == ST_RUN) && (r_cnt == CNT_W'(ITERS - 1));

  always_ff @(posedge clk) begin
    if (rst) r_state <= ST_IDLE;
    else     r_state <= w_state_nx;
  end

  always_comb begin
    w_state_nx = r_state;
    case (r_state)
      ST_IDLE: if (start)  w_state_nx = ST_RUN;
      ST_RUN:  if (w_last) w_state_nx = ST_IDLE;
      default: w_state_nx = ST_IDLE;
    endcase
  end

  mdu_negate #(.DATA_WIDTH(DATA_WIDTH)) u_neg_a (
    .i_en(op_is_signed(op) & a[DATA_WIDTH-1]), .i_data(a), .o_data(w_a_abs));
  mdu_negate #(.DATA_WIDTH(DATA_WIDTH)) u_neg_b (
    .i_en(op_is_signed(op) & b[DATA_WIDTH-1]), .i_data(b), .o_data(w_b_abs));

  // r_acc:r_mq is {partial product high, multiplier} for MULT, {remainder, dividend/quotient} for DIV
  assign w_mul_sum  = r_mq[0] ? ({1'b0, r_acc} + {1'b0, r_b}) : {1'b0, r_acc};
  assign w_div_sh   = {r_acc, r_mq[DATA_WIDTH-1]};
  assign w_div_diff = w_div_sh - {1'b0, r_b};
  assign w_div_ok   = ~w_div_diff[DATA_WIDTH];

  assign w_is_div = op_is_div(r_op);
  assign w_signed = op_is_signed(r_op);

  always_comb begin
    w_acc_nx = w_mul_sum[DATA_WIDTH:1];
    w_mq_nx  = {w_mul_sum[0], r_mq[DATA_WIDTH-1:1]};
    if (w_is_div) begin
      w_acc_nx = w_div_ok ? w_div_diff[DATA_WIDTH-1:0] : w_div_sh[DATA_WIDTH-1:0];
      w_mq_nx  = {r_mq[DATA_WIDTH-2:0], w_div_ok};
    end
  end

  // Negating a 2W product: LO negates normally, HI only takes the +1 carry when LO is zero
  assign w_q_neg     = w_signed & (r_sa ^ r_sb);
  assign w_lo_zero   = (w_mq_nx == '0);
  assign w_hi_neg_en = w_is_div ? (w_signed & r_sa) : (w_q_neg & w_lo_zero);

  mdu_negate #(.DATA_WIDTH(DATA_WIDTH)) u_neg_lo (
    .i_en(w_q_neg), .i_data(w_mq_nx), .o_data(w_lo_res));
  mdu_negate #(.DATA_WIDTH(DATA_WIDTH)) u_neg_hi (
    .i_en(w_hi_neg_en), .i_data(w_acc_nx), .o_data(w_hi_neg));

  assign w_hi_res = (!w_is_div && w_q_neg && !w_lo_zero) ? ~w_acc_nx : w_hi_neg;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_op       <= '0;
      r_sa       <= 1'b0;
      r_sb       <= 1'b0;
      r_dz       <= 1'b0;
      r_acc      <= '0;
      r_mq       <= '0;
      r_b        <= '0;
      r_cnt      <= '0;
      r_hi       <= '0;
      r_lo       <= '0;
      r_done     <= 1'b0;
      r_div_zero <= 1'b0;
    end else begin
      r_done     <= 1'b0;
      r_div_zero <= 1'b0;
      if (r_state == ST_IDLE) begin
        if (start) begin
          r_op  <= op;
          r_sa  <= a[DATA_WIDTH-1];
          r_sb  <= b[DATA_WIDTH-1];
          r_dz  <= op_is_div(op) && (b == '0);
          r_acc <= '0;
          r_mq  <= w_a_abs;
          r_b   <= w_b_abs;
          r_cnt <= '0;
        end else begin
          if (mthi) r_hi <= wdata;
          if (mtlo) r_lo <= wdata;
        end
      end else begin
        r_acc <= w_acc_nx;
        r_mq  <= w_mq_nx;
        r_cnt <= r_cnt + 1'b1;
        if (w_last) begin
          r_done     <= 1'b1;
          r_div_zero <= r_dz;
          if (!r_dz) begin
            r_hi <= w_hi_res;
            r_lo <= w_lo_res;
          end
        end
      end
    end
  end

  assign busy     = (r_state == ST_RUN);
  assign done     = r_done;
  assign div_zero = r_div_zero;
  assign hi       = r_hi;
  assign lo       = r_lo;

endmodule

// File: tb/tb_mdu_hilo.sv
// tb/tb_mdu_hilo.sv - directed self-checking bench for mdu_hilo
module tb_mdu_hilo;

  logic        clk = 1'b0;
  logic        rst, start, mthi, mtlo;
  logic [1:0]  op;
  logic [31:0] a, b, wdata;
  logic        busy, done, div_zero;
  logic [31:0] hi, lo;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  mdu_hilo #(.DATA_WIDTH(32)) dut (
    .clk(clk), .rst(rst), .start(start), .op(op), .a(a), .b(b),
    .mthi(mthi), .mtlo(mtlo), .wdata(wdata),
    .busy(busy), .done(done), .div_zero(div_zero), .hi(hi), .lo(lo)
  );

  task automatic do_op(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y,
                       output int cycles, output logic saw_done, output logic dz);
    @(negedge clk);
    op = o; a = x; b = y; start = 1'b1;
    @(negedge clk);
    start = 1'b0; op = ~o; a = ~x; b = y ^ 32'h5A5A_0001;
    cycles = 0;
    while (busy && cycles < 100) begin
      cycles++;
      @(negedge clk);
    end
    saw_done = done;
    dz = div_zero;
  endtask

  task automatic move(input logic h, input logic l, input logic [31:0] d);
    @(negedge clk);
    mthi = h; mtlo = l; wdata = d;
    @(negedge clk);
    mthi = 1'b0; mtlo = 1'b0;
  endtask

  task automatic test_reset;
    @(negedge clk);
    rst = 1'b1; mthi = 1'b1; mtlo = 1'b1; wdata = 32'hFFFF_FFFF;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0; mthi = 1'b0; mtlo = 1'b0;
    checks++;
    if ({busy, done, div_zero} !== 3'b000) begin
      errors++; $display("FAIL reset_flags: got %b expected 000", {busy, done, div_zero});
    end
    checks++;
    if (hi !== 32'h0 || lo !== 32'h0) begin
      errors++; $display("FAIL reset_hilo: got hi=%h lo=%h expected 0/0", hi, lo);
    end
  endtask

  task automatic test_moves;
    move(1'b1, 1'b1, 32'hCAFE_0001);
    checks++;
    if (hi !== 32'hCAFE_0001 || lo !== 32'hCAFE_0001) begin
      errors++; $display("FAIL mthi_mtlo_both: got hi=%h lo=%h expected cafe0001", hi, lo);
    end
    move(1'b0, 1'b1, 32'h0000_00AA);
    checks++;
    if (hi !== 32'hCAFE_0001 || lo !== 32'h0000_00AA) begin
      errors++; $display("FAIL mtlo_only: got hi=%h lo=%h expected cafe0001/000000aa", hi, lo);
    end
  endtask

  task automatic test_multu;
    int cyc; logic d, z;
    do_op(2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, cyc, d, z);
    checks++;
    if (cyc !== 32) begin errors++; $display("FAIL multu_busy_cycles: got %0d expected 32", cyc); end
    checks++;
    if (d !== 1'b1 || z !== 1'b0) begin
      errors++; $display("FAIL multu_done: got done=%b dz=%b expected 1/0", d, z);
    end
    checks++;
    if (hi !== 32'hFFFF_FFFE || lo !== 32'h0000_0001) begin
      errors++; $display("FAIL multu_result: got %h_%h expected fffffffe_00000001", hi, lo);
    end
    @(negedge clk);
    checks++;
    if (done !== 1'b0) begin errors++; $display("FAIL done_one_cycle: got %b expected 0", done); end
  endtask

  task automatic test_mult;
    int cyc; logic d, z;
    do_op(2'b00, 32'hFFFF_FFFE, 32'd3, cyc, d, z);
    checks++;
    if (hi !== 32'hFFFF_FFFF || lo !== 32'hFFFF_FFFA) begin
      errors++; $display("FAIL mult_neg: got %h_%h expected ffffffff_fffffffa", hi, lo);
    end
    do_op(2'b00, 32'hFFFF_0000, 32'h0001_0000, cyc, d, z);
    checks++;
    if (hi !== 32'hFFFF_FFFF || lo !== 32'h0000_0000) begin
      errors++; $display("FAIL mult_neg_lo_zero: got %h_%h expected ffffffff_00000000", hi, lo);
    end
    do_op(2'b00, 32'hFFFF_FFF9, 32'hFFFF_FFFD, cyc, d, z);
    checks++;
    if (hi !== 32'h0 || lo !== 32'd21) begin
      errors++; $display("FAIL mult_negneg: got %h_%h expected 00000000_00000015", hi, lo);
    end
  endtask

  task automatic test_div;
    int cyc; logic d, z;
    do_op(2'b10, 32'hFFFF_FFF9, 32'd2, cyc, d, z);
    checks++;
    if (lo !== 32'hFFFF_FFFD || hi !== 32'hFFFF_FFFF) begin
      errors++; $display("FAIL div_signed: got lo=%h hi=%h expected fffffffd/ffffffff", lo, hi);
    end
    do_op(2'b11, 32'd7, 32'd2, cyc, d, z);
    checks++;
    if (lo !== 32'd3 || hi !== 32'd1 || cyc !== 32) begin
      errors++; $display("FAIL divu: got lo=%h hi=%h cyc=%0d expected 3/1/32", lo, hi, cyc);
    end
    do_op(2'b10, 32'd7, 32'hFFFF_FFFE, cyc, d, z);
    checks++;
    if (lo !== 32'hFFFF_FFFD || hi !== 32'd1) begin
      errors++; $display("FAIL div_pos_neg: got lo=%h hi=%h expected fffffffd/00000001", lo, hi);
    end
    do_op(2'b10, 32'h8000_0000, 32'hFFFF_FFFF, cyc, d, z);
    checks++;
    if (lo !== 32'h8000_0000 || hi !== 32'h0 || z !== 1'b0) begin
      errors++; $display("FAIL div_overflow: got lo=%h hi=%h dz=%b expected 80000000/0/0", lo, hi, z);
    end
    do_op(2'b11, 32'hFFFF_FFFF, 32'h8000_0000, cyc, d, z);
    checks++;
    if (lo !== 32'd1 || hi !== 32'h7FFF_FFFF) begin
      errors++; $display("FAIL divu_large: got lo=%h hi=%h expected 1/7fffffff", lo, hi);
    end
  endtask

  task automatic test_div_zero;
    int cyc; logic d, z;
    move(1'b1, 1'b0, 32'h0000_1234);
    move(1'b0, 1'b1, 32'h0000_5678);
    do_op(2'b11, 32'd5, 32'd0, cyc, d, z);
    checks++;
    if (cyc !== 32 || d !== 1'b1 || z !== 1'b1) begin
      errors++; $display("FAIL div_zero_flag: got cyc=%0d done=%b dz=%b expected 32/1/1", cyc, d, z);
    end
    checks++;
    if (hi !== 32'h0000_1234 || lo !== 32'h0000_5678) begin
      errors++; $display("FAIL div_zero_hilo: got hi=%h lo=%h expected 00001234/00005678", hi, lo);
    end
  endtask

  task automatic test_busy_then_reset;
    int saw;
    move(1'b1, 1'b1, 32'h1111_2222);
    @(negedge clk);
    op = 2'b01; a = 32'd1000; b = 32'd1000; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (9) @(negedge clk);
    start = 1'b1; op = 2'b11; mtlo = 1'b1; mthi = 1'b1; wdata = 32'h9999_9999;
    @(negedge clk);
    start = 1'b0; mtlo = 1'b0; mthi = 1'b0;
    checks++;
    if (hi !== 32'h1111_2222 || lo !== 32'h1111_2222 || busy !== 1'b1) begin
      errors++; $display("FAIL move_while_busy: got hi=%h lo=%h busy=%b expected 11112222/11112222/1", hi, lo, busy);
    end
    repeat (9) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    checks++;
    if (busy !== 1'b0 || hi !== 32'h0 || lo !== 32'h0 || done !== 1'b0) begin
      errors++; $display("FAIL mid_run_reset: got busy=%b hi=%h lo=%h done=%b expected 0/0/0/0", busy, hi, lo, done);
    end
    saw = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (done || busy) saw++;
    end
    checks++;
    if (saw !== 0) begin errors++; $display("FAIL no_done_after_reset: got %0d active cycles expected 0", saw); end
  endtask

  task automatic test_start_with_mthi;
    int cyc;
    @(negedge clk);
    op = 2'b11; a = 32'd9; b = 32'd4; start = 1'b1; mthi = 1'b1; wdata = 32'h0000_DEAD;
    @(negedge clk);
    start = 1'b0; mthi = 1'b0;
    checks++;
    if (hi !== 32'h0 || busy !== 1'b1) begin
      errors++; $display("FAIL start_drops_mthi: got hi=%h busy=%b expected 0/1", hi, busy);
    end
    cyc = 0;
    while (busy && cyc < 100) begin cyc++; @(negedge clk); end
    checks++;
    if (hi !== 32'd1 || lo !== 32'd2 || done !== 1'b1) begin
      errors++; $display("FAIL start_mthi_result: got hi=%h lo=%h done=%b expected 1/2/1", hi, lo, done);
    end
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; mthi = 1'b0; mtlo = 1'b0;
    op = 2'b00; a = '0; b = '0; wdata = '0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    test_reset();
    test_moves();
    test_multu();
    test_mult();
    test_div();
    test_div_zero();
    test_busy_then_reset();
    test_start_with_mthi();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/mdu_hilo.md
MDU_HILO -- requirements
Module: mdu_hilo

Interface
REQ-001 Parameter: DATA_WIDTH, default 32, operand/result width; all datapath widths below scale with it.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst  input  1  reset, synchronous, active-high.
REQ-004 start  input  1  request a multiply/divide; sampled only when busy=0.
REQ-005 op  input  2  00 MULT (signed), 01 MULTU, 10 DIV (signed), 11 DIVU.
REQ-006 a  input  DATA_WIDTH  multiplicand / dividend (rs).
REQ-007 b  input  DATA_WIDTH  multiplier / divisor (rt).
REQ-008 mthi  input  1  write wdata into HI.
REQ-009 mtlo  input  1  write wdata into LO.
REQ-010 wdata  input  DATA_WIDTH  data for mthi/mtlo.
REQ-011 busy  output  1  operation in progress; pipeline stalls MFHI/MFLO/MDU ops while high.
REQ-012 done  output  1  one-cycle pulse, HI/LO just updated by an operation.
REQ-013 div_zero  output  1  registered; set with done when a DIV/DIVU had b=0.
REQ-014 hi  output  DATA_WIDTH  HI register; feeds the writeback result-select multiplexer.
REQ-015 lo  output  DATA_WIDTH  LO register; feeds the writeback result-select multiplexer.

Function
REQ-016 FSM states IDLE and RUN; busy = (state==RUN), registered.
REQ-017 IDLE + start at edge E0: latch a, b, op; capture operand signs; load |a|,|b| (signed ops) or raw values; counter=0; go RUN.
REQ-018 RUN performs exactly one iteration per cycle (shift-add for multiply, restoring shift-subtract for divide) at edges E1..E32; busy high for 32 cycles.
REQ-019 At E32: apply sign correction, write HI/LO, set done=1 for one cycle, return IDLE; results visible from the cycle after E32.
REQ-020 Multiply: {HI,LO} = full 2*DATA_WIDTH product; MULT signed two's complement, MULTU unsigned.
REQ-021 Divide: LO=quotient, HI=remainder; signed quotient truncates toward zero, remainder sign equals dividend sign.
REQ-022 DIV 0x80000000 / 0xFFFFFFFF: LO=0x80000000, HI=0, no flag.
REQ-023 Divide by zero: still takes 32 cycles, done pulses, HI/LO left unchanged, div_zero=1 in the done cycle; div_zero=0 on every other done.
REQ-024 start while busy: ignored, no queuing.
REQ-025 mthi/mtlo in IDLE: register written at that edge; both may assert together.
REQ-026 mthi/mtlo while busy: ignored.
REQ-027 start with mthi/mtlo in the same IDLE cycle: start taken, moves dropped.
REQ-028 Changes on a/b/op after E0 do not affect the running operation.

Reset
REQ-029 rst at any edge, including mid-RUN: state=IDLE, busy=0, done=0, div_zero=0, hi=0, lo=0, counter=0; in-flight operation discarded.
REQ-030 rst has priority over start, mthi, mtlo.

Structure
REQ-031 Shared package mdu_pkg holds op encodings, state enum, DATA_WIDTH default, iteration count constant (DATA_WIDTH).
REQ-032 One sub-module, mdu_negate (conditional two's-complement of a DATA_WIDTH word), instanced for operand abs and result correction.

Verification
REQ-033 MULTU a=0xFFFFFFFF b=0xFFFFFFFF -> busy 32 cycles, done pulse, HI=0xFFFFFFFE LO=0x00000001.
REQ-034 MULT a=0xFFFFFFFE(-2) b=3 -> HI=0xFFFFFFFF LO=0xFFFFFFFA.
REQ-035 DIV a=-7 b=2 -> LO=0xFFFFFFFD(-3), HI=0xFFFFFFFF(-1); DIVU a=7 b=2 -> LO=3 HI=1.
REQ-036 mthi 0x1234, then DIVU a=5 b=0 -> after 32 cycles done=1, div_zero=1, HI=0x1234 unchanged.
REQ-037 Start MULTU, assert start+mtlo at cycle 10, rst at cycle 20 -> second start and mtlo ignored; after rst busy=0, hi=lo=0, no done pulse.
REQ-038 IDLE: start (DIVU 9/4) with mthi=1 same cycle -> HI=1 LO=2, mthi value never appears.
